pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Control FSM that drives the program_counter's reset_enable, update_enable and value inputs.
- Sequences each instruction through fetch from instruction memory, hand-off to the execute stage, and the PC update (sequential +1 or signed branch offset).
- Handles halt, fetch timeout fault and restart.
- Sits between program_counter, instruction memory and the CPU core execute logic.

Parameters:
- WORD_SIZE, 32, instruction/offset width (shared header value).
- MEM_ADDR_SIZE, 16, instruction address width (shared header value).
- FETCH_TIMEOUT, 16, max consecutive FETCH cycles without fetch_ready before FAULT; legal range 1..255.

Ports:
- clock  in  1  system clock, all state on rising edge
- reset_n  in  1  synchronous active-low reset
- start  in  1  begin or restart execution from address 0
- pc_addr  in  MEM_ADDR_SIZE  current program_counter out
- pc_reset_enable  out  1  to program_counter reset_enable
- pc_update_enable  out  1  to program_counter update_enable
- pc_offset  out  WORD_SIZE  to program_counter value (signed)
- fetch_req  out  1  instruction read request
- fetch_addr  out  MEM_ADDR_SIZE  read address
- fetch_ready  in  1  memory data valid
- fetch_data  in  WORD_SIZE  instruction word
- instr  out  WORD_SIZE  latched instruction
- instr_valid  out  1  one-cycle pulse: instr ready for execute
- exec_done  in  1  execute stage finished
- branch_taken  in  1  sampled with exec_done
- branch_offset  in  WORD_SIZE  signed, sampled with exec_done
- halt  in  1  sampled with exec_done
- retired  out  WORD_SIZE  retired-instruction count, saturating
- fault  out  1  fetch timeout occurred
- state  out  3  current FSM state, for debug

Behaviour:
- Reset (reset_n=0 at a clock edge) has priority over everything, including mid-fetch and mid-execute.
  - Next state is IDLE.
  - All outputs are 0, instr=0, retired=0, timer=0.
  - The sequencer does not pulse pc_reset_enable on reset.
- States (encoding): IDLE=0, RESETPC=1, FETCH=2, EXECUTE=3, UPDATE=4, HALTED=5, FAULT=6.
- All control outputs are registered and depend on state only, except instr_valid.
- IDLE: all outputs 0; start=1 -> RESETPC.
- RESETPC: pc_reset_enable=1 for exactly one cycle -> FETCH.
- FETCH:
  - fetch_req=1 and fetch_addr=pc_addr for every cycle in the state.
  - fetch_ready=1: capture fetch_data into instr -> EXECUTE.
  - fetch_ready=0: timer increments. If the timer is already FETCH_TIMEOUT-1 -> FAULT.
  - Result: ready on the FETCH_TIMEOUT-th cycle is accepted; ready on the next cycle is too late.
  - Timer clears on every FETCH entry.
- EXECUTE:
  - instr_valid=1 on the first EXECUTE cycle only.
  - instr is held stable.
  - Wait for exec_done; exec_done on the first cycle is legal.
  - On exec_done with halt=1 -> HALTED. No PC update; retired increments. halt beats branch_taken.
  - On exec_done without halt, latch pc_offset = branch_taken ? branch_offset : 1 -> UPDATE.
- UPDATE:
  - pc_update_enable=1 for exactly one cycle, with pc_offset stable; retired increments -> FETCH.
  - The PC changes at the end of UPDATE, so FETCH sees the new pc_addr on its first cycle.
- HALTED: all strobes 0, instr and retired held; start=1 -> RESETPC (retired not cleared).
- FAULT: fault=1, all strobes 0; exit only via reset_n=0; start ignored.
- Inputs ignored outside their state: fetch_ready outside FETCH, exec_done/halt/branch_* outside EXECUTE, start outside IDLE/HALTED.
- Arithmetic:
  - pc_offset is passed unchanged as a signed two's-complement value.
  - PC wrap-around (modulo 2^MEM_ADDR_SIZE) is program_counter behaviour; the sequencer performs no range check.
  - branch_offset=0 (self-loop) is legal.
  - retired saturates at all-ones.
- Throughput: minimum 3 cycles per instruction (FETCH, EXECUTE, UPDATE). Start-to-first-fetch_req latency is 2 cycles.

Decomposition:
- State encodings and FETCH_TIMEOUT default go into the shared parameters.vh header alongside WORD_SIZE and MEM_ADDR_SIZE.
- One sub-module, fetch_watchdog.
  - Contents: timer with clear, increment and expired output; 8-bit counter.
  - Rest: FSM and datapath registers stay in pc_sequencer.

Test Plan:
- Reset then start=1: pc_reset_enable high exactly 1 cycle, fetch_req next cycle with fetch_addr=0; state sequence 0->1->2.
- Straight line: ready immediate with data 0xA5, exec_done immediate, no branch.
  - instr=0xA5 and instr_valid pulses once.
  - pc_update_enable pulses with pc_offset=1.
  - 3 cycles per instruction; retired=3 after 3 instructions.
- Branch: exec_done, branch_taken=1, branch_offset=-4 (0xFFFFFFFC) -> pc_offset=0xFFFFFFFC during UPDATE. Halt+branch together -> HALTED, no update pulse, retired+1.
- Timeout, FETCH_TIMEOUT=16:
  - ready on the 16th FETCH cycle -> EXECUTE.
  - ready withheld 16 cycles -> FAULT, fault=1.
  - start ignored in FAULT; reset_n=0 clears fault.
- Mid-operation reset: reset_n=0 during EXECUTE with exec_done=1 -> IDLE, no pc_update_enable, instr=0, retired=0.
- Restart: from HALTED, start=1 -> RESETPC pulse, fetch from address 0, retired continues counting.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// rtl/pc_sequencer_pkg.sv - shared widths, timeout default and FSM state encodings
package pc_sequencer_pkg;

    localparam int DEF_WORD_SIZE     = 32;
    localparam int DEF_MEM_ADDR_SIZE = 16;
    localparam int DEF_FETCH_TIMEOUT = 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RESETPC = 3'd1,
        ST_FETCH   = 3'd2,
        ST_EXECUTE = 3'd3,
        ST_UPDATE  = 3'd4,
        ST_HALTED  = 3'd5,
        ST_FAULT   = 3'd6
    } state_t;

endpackage

// File: rtl/fetch_watchdog.sv
// rtl/fetch_watchdog.sv - 8-bit fetch wait counter with clear, increment and expiry flag
module fetch_watchdog #(
    parameter int TIMEOUT = 16
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic increment,
    output logic expired
);

    logic [7:0] count;

    // Count stalled fetch cycles; clear wins so every FETCH entry starts at zero
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            count <= 8'd0;
        end else if (clear) begin
            count <= 8'd0;
        end else if (increment) begin
            count <= count + 8'd1;
        end
    end

    // Expired means the current stalled cycle is the last one allowed
    assign expired = (count == 8'(TIMEOUT - 1));

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch/execute/update control FSM driving the program counter
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int WORD_SIZE     = DEF_WORD_SIZE,
    parameter int MEM_ADDR_SIZE = DEF_MEM_ADDR_SIZE,
    parameter int FETCH_TIMEOUT = DEF_FETCH_TIMEOUT
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic [MEM_ADDR_SIZE-1:0] pc_addr,
    output logic                     pc_reset_enable,
    output logic                     pc_update_enable,
    output logic [WORD_SIZE-1:0]     pc_offset,
    output logic                     fetch_req,
    output logic [MEM_ADDR_SIZE-1:0] fetch_addr,
    input  logic                     fetch_ready,
    input  logic [WORD_SIZE-1:0]     fetch_data,
    output logic [WORD_SIZE-1:0]     instr,
    output logic                     instr_valid,
    input  logic                     exec_done,
    input  logic                     branch_taken,
    input  logic [WORD_SIZE-1:0]     branch_offset,
    input  logic                     halt,
    output logic [WORD_SIZE-1:0]     retired,
    output logic                     fault,
    output logic [2:0]               state
);

    state_t state_q;
    state_t state_d;
    logic   wd_expired;
    logic   retire;

    fetch_watchdog #(
        .TIMEOUT (FETCH_TIMEOUT)
    ) u_fetch_watchdog (
        .clock     (clock),
        .reset_n   (reset_n),
        .clear     ((state_q != ST_FETCH) || fetch_ready),
        .increment ((state_q == ST_FETCH) && !fetch_ready),
        .expired   (wd_expired)
    );

    // State register; reset overrides any in-flight fetch or execute
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode; each state only looks at the inputs that belong to it
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (start) state_d = ST_RESETPC;
            ST_RESETPC: state_d = ST_FETCH;
            ST_FETCH: begin
                if (fetch_ready)     state_d = ST_EXECUTE;
                else if (wd_expired) state_d = ST_FAULT;
            end
            ST_EXECUTE: begin
                if (exec_done) state_d = halt ? ST_HALTED : ST_UPDATE;
            end
            ST_UPDATE:  state_d = ST_FETCH;
            ST_HALTED:  if (start) state_d = ST_RESETPC;
            ST_FAULT:   state_d = ST_FAULT;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Control strobes decoded from the registered state only
    always_comb begin
        pc_reset_enable  = (state_q == ST_RESETPC);
        pc_update_enable = (state_q == ST_UPDATE);
        fetch_req        = (state_q == ST_FETCH);
        fetch_addr       = (state_q == ST_FETCH) ? pc_addr : '0;
        fault            = (state_q == ST_FAULT);
        state            = state_q;
    end

    // A halting instruction retires in EXECUTE, every other one in UPDATE
    assign retire = (state_q == ST_UPDATE) ||
                    ((state_q == ST_EXECUTE) && exec_done && halt);

    // Datapath: instruction latch, valid pulse, offset latch, saturating retire count
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            instr       <= '0;
            instr_valid <= 1'b0;
            pc_offset   <= '0;
            retired     <= '0;
        end else begin
            instr_valid <= (state_q == ST_FETCH) && fetch_ready;
            if ((state_q == ST_FETCH) && fetch_ready) begin
                instr <= fetch_data;
            end
            if ((state_q == ST_EXECUTE) && exec_done && !halt) begin
                pc_offset <= branch_taken ? branch_offset : WORD_SIZE'(1);
            end
            if (retire && (retired != '1)) begin
                retired <= retired + WORD_SIZE'(1);
            end
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed self-checking bench for pc_sequencer
module tb_pc_sequencer;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic [15:0] pc_addr;
    logic        pc_reset_enable;
    logic        pc_update_enable;
    logic [31:0] pc_offset;
    logic        fetch_req;
    logic [15:0] fetch_addr;
    logic        fetch_ready;
    logic [31:0] fetch_data;
    logic [31:0] instr;
    logic        instr_valid;
    logic        exec_done;
    logic        branch_taken;
    logic [31:0] branch_offset;
    logic        halt;
    logic [31:0] retired;
    logic        fault;
    logic [2:0]  state;

    int checks = 0;
    int errors = 0;

    pc_sequencer dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .start            (start),
        .pc_addr          (pc_addr),
        .pc_reset_enable  (pc_reset_enable),
        .pc_update_enable (pc_update_enable),
        .pc_offset        (pc_offset),
        .fetch_req        (fetch_req),
        .fetch_addr       (fetch_addr),
        .fetch_ready      (fetch_ready),
        .fetch_data       (fetch_data),
        .instr            (instr),
        .instr_valid      (instr_valid),
        .exec_done        (exec_done),
        .branch_taken     (branch_taken),
        .branch_offset    (branch_offset),
        .halt             (halt),
        .retired          (retired),
        .fault            (fault),
        .state            (state)
    );

    always #5 clock = ~clock;

    // Stand-in program counter fed by the sequencer strobes
    always @(posedge clock) begin
        if (!reset_n)              pc_addr <= 16'd0;
        else if (pc_reset_enable)  pc_addr <= 16'd0;
        else if (pc_update_enable) pc_addr <= pc_addr + pc_offset[15:0];
    end

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset;
        reset_n = 1'b0; start = 1'b0; fetch_ready = 1'b0; fetch_data = '0;
        exec_done = 1'b0; branch_taken = 1'b0; branch_offset = '0; halt = 1'b0;
        step; step;
        checks++;
        if (state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state); end
        checks++;
        if ({pc_reset_enable, pc_update_enable, fetch_req, instr_valid, fault} !== 5'b0) begin
            errors++; $display("FAIL reset_strobes: got %b want 00000",
                {pc_reset_enable, pc_update_enable, fetch_req, instr_valid, fault});
        end
        checks++;
        if (instr !== 32'd0 || retired !== 32'd0 || pc_offset !== 32'd0) begin
            errors++; $display("FAIL reset_regs: got instr=%h retired=%0d off=%h want 0", instr, retired, pc_offset);
        end
    endtask

    task automatic test_start;
        reset_n = 1'b1; start = 1'b1;
        step;
        start = 1'b0;
        checks++;
        if (state !== 3'd1 || pc_reset_enable !== 1'b1 || fetch_req !== 1'b0) begin
            errors++; $display("FAIL start_resetpc: got state=%0d pre=%b req=%b want 1 1 0", state, pc_reset_enable, fetch_req);
        end
        step;
        checks++;
        if (state !== 3'd2 || pc_reset_enable !== 1'b0 || fetch_req !== 1'b1 || fetch_addr !== 16'd0) begin
            errors++; $display("FAIL start_fetch: got state=%0d pre=%b req=%b addr=%h want 2 0 1 0000",
                state, pc_reset_enable, fetch_req, fetch_addr);
        end
    endtask

    task automatic test_straight_line;
        for (int i = 0; i < 3; i++) begin
            fetch_ready = 1'b1; fetch_data = 32'hA5;
            step;
            fetch_ready = 1'b0; exec_done = 1'b1;
            checks++;
            if (state !== 3'd3 || instr !== 32'hA5 || instr_valid !== 1'b1) begin
                errors++; $display("FAIL straight_exec%0d: got state=%0d instr=%h valid=%b want 3 a5 1", i, state, instr, instr_valid);
            end
            step;
            exec_done = 1'b0;
            checks++;
            if (state !== 3'd4 || pc_update_enable !== 1'b1 || pc_offset !== 32'd1 || instr_valid !== 1'b0) begin
                errors++; $display("FAIL straight_update%0d: got state=%0d upd=%b off=%h valid=%b want 4 1 1 0",
                    i, state, pc_update_enable, pc_offset, instr_valid);
            end
            step;
            checks++;
            if (state !== 3'd2 || fetch_addr !== 16'(i + 1) || pc_update_enable !== 1'b0) begin
                errors++; $display("FAIL straight_fetch%0d: got state=%0d addr=%0d upd=%b want 2 %0d 0",
                    i, state, fetch_addr, pc_update_enable, i + 1);
            end
        end
        checks++;
        if (retired !== 32'd3) begin errors++; $display("FAIL straight_retired: got %0d want 3", retired); end
    endtask

    task automatic test_branch;
        fetch_ready = 1'b1; fetch_data = 32'h1234_5678;
        step;
        fetch_ready = 1'b0; exec_done = 1'b1; branch_taken = 1'b1; branch_offset = 32'hFFFF_FFFC;
        step;
        exec_done = 1'b0; branch_taken = 1'b0;
        checks++;
        if (state !== 3'd4 || pc_offset !== 32'hFFFF_FFFC) begin
            errors++; $display("FAIL branch_offset: got state=%0d off=%h want 4 fffffffc", state, pc_offset);
        end
        step;
        checks++;
        if (fetch_addr !== 16'hFFFF || retired !== 32'd4) begin
            errors++; $display("FAIL branch_target: got addr=%h retired=%0d want ffff 4", fetch_addr, retired);
        end
        fetch_ready = 1'b1; fetch_data = 32'hDEAD_0001;
        step;
        fetch_ready = 1'b0; exec_done = 1'b1; halt = 1'b1; branch_taken = 1'b1; branch_offset = 32'd8;
        step;
        exec_done = 1'b0; halt = 1'b0; branch_taken = 1'b0;
        checks++;
        if (state !== 3'd5 || pc_update_enable !== 1'b0 || retired !== 32'd5) begin
            errors++; $display("FAIL halt_branch: got state=%0d upd=%b retired=%0d want 5 0 5", state, pc_update_enable, retired);
        end
        step;
        checks++;
        if (state !== 3'd5 || fetch_req !== 1'b0 || instr !== 32'hDEAD_0001 || pc_offset !== 32'hFFFF_FFFC) begin
            errors++; $display("FAIL halted_hold: got state=%0d req=%b instr=%h off=%h want 5 0 dead0001 fffffffc",
                state, fetch_req, instr, pc_offset);
        end
    endtask

    task automatic test_restart;
        start = 1'b1;
        step;
        start = 1'b0;
        checks++;
        if (state !== 3'd1 || pc_reset_enable !== 1'b1) begin
            errors++; $display("FAIL restart_resetpc: got state=%0d pre=%b want 1 1", state, pc_reset_enable);
        end
        step;
        checks++;
        if (state !== 3'd2 || fetch_addr !== 16'd0 || retired !== 32'd5) begin
            errors++; $display("FAIL restart_fetch: got state=%0d addr=%h retired=%0d want 2 0 5", state, fetch_addr, retired);
        end
        fetch_ready = 1'b1; fetch_data = 32'h77;
        step;
        fetch_ready = 1'b0; exec_done = 1'b1;
        step;
        exec_done = 1'b0;
        step;
        checks++;
        if (retired !== 32'd6 || fetch_addr !== 16'd1) begin
            errors++; $display("FAIL restart_count: got retired=%0d addr=%0d want 6 1", retired, fetch_addr);
        end
    endtask

    task automatic test_timeout;
        int stalls;
        stalls = 0;
        for (int i = 1; i <= 15; i++) begin
            step;
            if (state == 3'd2) stalls++;
        end
        checks++;
        if (stalls !== 15) begin errors++; $display("FAIL timeout_stall: got %0d fetch cycles want 15", stalls); end
        fetch_ready = 1'b1; fetch_data = 32'h16;
        step;
        fetch_ready = 1'b0;
        checks++;
        if (state !== 3'd3 || instr !== 32'h16) begin
            errors++; $display("FAIL timeout_last_ready: got state=%0d instr=%h want 3 16", state, instr);
        end
        exec_done = 1'b1;
        step;
        exec_done = 1'b0;
        step;
        for (int i = 1; i <= 15; i++) step;
        checks++;
        if (state !== 3'd2 || fault !== 1'b0) begin
            errors++; $display("FAIL timeout_pre: got state=%0d fault=%b want 2 0", state, fault);
        end
        step;
        checks++;
        if (state !== 3'd6 || fault !== 1'b1 || fetch_req !== 1'b0) begin
            errors++; $display("FAIL timeout_fault: got state=%0d fault=%b req=%b want 6 1 0", state, fault, fetch_req);
        end
        start = 1'b1; fetch_ready = 1'b1;
        step; step;
        start = 1'b0; fetch_ready = 1'b0;
        checks++;
        if (state !== 3'd6 || fault !== 1'b1) begin
            errors++; $display("FAIL fault_sticky: got state=%0d fault=%b want 6 1", state, fault);
        end
        reset_n = 1'b0;
        step;
        reset_n = 1'b1;
        checks++;
        if (state !== 3'd0 || fault !== 1'b0 || retired !== 32'd0) begin
            errors++; $display("FAIL fault_clear: got state=%0d fault=%b retired=%0d want 0 0 0", state, fault, retired);
        end
    endtask

    task automatic test_mid_reset;
        start = 1'b1;
        step;
        start = 1'b0;
        step;
        fetch_ready = 1'b1; fetch_data = 32'hCAFE;
        step;
        fetch_ready = 1'b0;
        checks++;
        if (state !== 3'd3 || instr !== 32'hCAFE) begin
            errors++; $display("FAIL mid_setup: got state=%0d instr=%h want 3 cafe", state, instr);
        end
        exec_done = 1'b1; reset_n = 1'b0;
        step;
        exec_done = 1'b0; reset_n = 1'b1;
        checks++;
        if (state !== 3'd0 || pc_update_enable !== 1'b0 || instr !== 32'd0 || retired !== 32'd0) begin
            errors++; $display("FAIL mid_reset: got state=%0d upd=%b instr=%h retired=%0d want 0 0 0 0",
                state, pc_update_enable, instr, retired);
        end
        step;
        checks++;
        if (state !== 3'd0 || pc_update_enable !== 1'b0 || pc_reset_enable !== 1'b0) begin
            errors++; $display("FAIL mid_idle: got state=%0d upd=%b pre=%b want 0 0 0", state, pc_update_enable, pc_reset_enable);
        end
    endtask

    initial begin
        test_reset;
        test_start;
        test_straight_line;
        test_branch;
        test_restart;
        test_timeout;
        test_mid_reset;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
